// File: rtl/fp_align_seq.sv
// Iterative exponent-alignment sequencer for the FP add/sub path: picks the larger
// exponent and right-shifts the other fraction up to STEP bits per cycle. Sticky tracking is enabled by FP_ALIGN_STICKY_EN.
module fp_align_seq #(
    parameter int STEP = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [25:0] frac_a,
    input  logic [25:0] frac_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_out,
    output logic [25:0] frac_big,
    output logic [25:0] frac_small,
    output logic [22:0] frac_small_top,
    output logic        swapped,
    output logic        sticky
);
    typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

    localparam logic [7:0] STEP_K = 8'(STEP);

    state_t      state_q, state_d;
    logic [7:0]  ea_q, ea_d, eb_q, eb_d;
    logic [25:0] fa_q, fa_d, fb_q, fb_d;
    logic [7:0]  exp_q, exp_d;
    logic [25:0] big_q, big_d, small_q, small_d;
    logic        swp_q, swp_d;
    logic [7:0]  rem_q, rem_d;

    logic        b_wins;
    logic [7:0]  diff;
    logic [25:0] cmp_small;
    logic [7:0]  k;

    assign b_wins    = eb_q > ea_q;
    assign diff      = b_wins ? (eb_q - ea_q) : (ea_q - eb_q);
    assign cmp_small = b_wins ? fa_q : fb_q;
    assign k         = (rem_q < STEP_K) ? rem_q : STEP_K;

`ifdef FP_ALIGN_STICKY_EN
    logic        sticky_q, sticky_d;
    logic [25:0] lost_mask;
    // Bits about to fall off the bottom on this SHIFT cycle.
    assign lost_mask = ~(26'h3FFFFFF << k);
`endif

    always_comb begin
        state_d = state_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        exp_d   = exp_q;
        big_d   = big_q;
        small_d = small_q;
        swp_d   = swp_q;
        rem_d   = rem_q;
`ifdef FP_ALIGN_STICKY_EN
        sticky_d = sticky_q;
`endif
        if (flush) begin
            state_d = IDLE;
            rem_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    ea_d    = exp_a;
                    eb_d    = exp_b;
                    fa_d    = frac_a;
                    fb_d    = frac_b;
`ifdef FP_ALIGN_STICKY_EN
                    sticky_d = 1'b0;
`endif
                    state_d = CMP;
                end
                CMP: begin
                    swp_d   = b_wins;
                    exp_d   = b_wins ? eb_q : ea_q;
                    big_d   = b_wins ? fb_q : fa_q;
                    small_d = cmp_small;
                    if (diff == 8'd0) begin
                        state_d = DONE;
                    end else if (diff >= 8'd26) begin
                        small_d = 26'd0;
`ifdef FP_ALIGN_STICKY_EN
                        sticky_d = |cmp_small;
`endif
                        state_d = DONE;
                    end else begin
                        rem_d   = diff;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    small_d = small_q >> k;
                    rem_d   = rem_q - k;
`ifdef FP_ALIGN_STICKY_EN
                    sticky_d = sticky_q | (|(small_q & lost_mask));
`endif
                    if (rem_q == k) state_d = DONE;
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            ea_q    <= '0;
            eb_q    <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            exp_q   <= '0;
            big_q   <= '0;
            small_q <= '0;
            swp_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            exp_q   <= exp_d;
            big_q   <= big_d;
            small_q <= small_d;
            swp_q   <= swp_d;
            rem_q   <= rem_d;
        end
    end

`ifdef FP_ALIGN_STICKY_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) sticky_q <= 1'b0;
        else       sticky_q <= sticky_d;
    end
    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == DONE);
    assign exp_out        = exp_q;
    assign frac_big       = big_q;
    assign frac_small     = small_q;
    assign frac_small_top = small_q[25:3];
    assign swapped        = swp_q;
endmodule
